// File: rtl/stencil_jacobi_solver.sv
// Parametrised 5-point Jacobi heat solver with double-buffered grid banks.
// Optional convergence stop/max_delta logic: define STENCIL_CONVERGE_EN.
module stencil_jacobi_solver #(
  parameter  int GRID_W = 8,
  parameter  int GRID_H = 8,
  parameter  int TW     = 6,
  parameter  int ITER_W = 12,
  localparam int CELLS  = GRID_W * GRID_H,
  localparam int AW     = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [ITER_W-1:0] cmd_data,
  input  logic              abort,
  output logic              rsp_valid,
  output logic [TW-1:0]     rsp_data,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic [TW-1:0]     max_delta
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = AW - XW;

  typedef enum logic [1:0] {
    S_IDLE, S_SWEEP, S_SWAP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic              bank_q, bank_d;
  logic [AW-1:0]     k_q, k_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iter_next;
  logic [1:0]        alpha_q, alpha_d;
  logic              bc_q, bc_d;
  logic [TW-1:0]     bnd_q, bnd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [TW-1:0]     rsp_data_q, rsp_data_d;

  logic [TW-1:0]     mem_q [2][CELLS];
  logic              we;
  logic              wbank;
  logic [AW-1:0]     waddr;
  logic [TW-1:0]     wdata;

  logic              accept;
  logic              op_run, op_wr, op_rd, op_cfg;
  logic              conv_stop;

`ifdef STENCIL_CONVERGE_EN
  logic [TW-1:0]     thr_q, thr_d;
  logic [TW-1:0]     drun_q, drun_d;
  logic [TW-1:0]     mdel_q, mdel_d;
  logic [TW-1:0]     dlt;
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign op_run    = (cmd_op == 2'b00);
  assign op_wr     = (cmd_op == 2'b01);
  assign op_rd     = (cmd_op == 2'b10);
  assign op_cfg    = (cmd_op == 2'b11);
  assign iter_next = iter_q + ITER_W'(1);

  // Stencil datapath for the cell currently addressed by k_q
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic            on_edge;
  logic [TW-1:0]   c_v, l_v, r_v, u_v, d_v;
  logic [TW+1:0]   sum;
  logic [TW-1:0]   avg;
  logic [TW+2:0]   cw, aw;
  logic [TW-1:0]   stencil;
  logic [TW-1:0]   new_val;

  assign cx  = k_q[XW-1:0];
  assign cy  = k_q[AW-1:XW];
  assign c_v = mem_q[bank_q][k_q];

  assign l_v = (cx == '0) ? c_v
             : mem_q[bank_q][k_q - AW'(1)];
  assign r_v = (cx == XW'(GRID_W-1)) ? c_v
             : mem_q[bank_q][k_q + AW'(1)];
  assign u_v = (cy == '0) ? c_v
             : mem_q[bank_q][k_q - AW'(GRID_W)];
  assign d_v = (cy == YW'(GRID_H-1)) ? c_v
             : mem_q[bank_q][k_q + AW'(GRID_W)];

  assign on_edge = (cx == '0) || (cx == XW'(GRID_W-1)) ||
                   (cy == '0) || (cy == YW'(GRID_H-1));

  assign sum = {2'b00, l_v} + {2'b00, r_v} +
               {2'b00, u_v} + {2'b00, d_v};
  assign avg = TW'(sum >> 2);
  assign cw  = {3'b000, c_v};
  assign aw  = {3'b000, avg};

  always_comb begin
    stencil = '0;
    unique case (alpha_q)
      2'b00: stencil = TW'(((cw << 3) - cw + aw) >> 3);
      2'b01: stencil = TW'(((cw << 1) + cw + aw) >> 2);
      2'b10: stencil = TW'((cw + aw) >> 1);
      2'b11: stencil = TW'((cw + (aw << 1) + aw) >> 2);
      default: stencil = '0;
    endcase
  end

  assign new_val = (on_edge && !bc_q) ? bnd_q : stencil;

`ifdef STENCIL_CONVERGE_EN
  assign dlt       = (new_val >= c_v) ? (new_val - c_v)
                                      : (c_v - new_val);
  assign conv_stop = (drun_q <= thr_q);
  assign max_delta = mdel_q;
`else
  assign conv_stop = 1'b0;
  assign max_delta = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state; abort outranks the normal SWAP exit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && op_run)
          state_d = (cmd_data == '0) ? S_DONE : S_SWEEP;
      end
      S_SWEEP: begin
        if (abort)                         state_d = S_DONE;
        else if (k_q == AW'(CELLS-1))      state_d = S_SWAP;
      end
      S_SWAP: begin
        if (abort)                         state_d = S_DONE;
        else if (iter_next == n_q || conv_stop)
                                           state_d = S_DONE;
        else                               state_d = S_SWEEP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_SWEEP) || (state_q == S_SWAP);
    done      = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    bank_d      = bank_q;
    k_d         = k_q;
    n_d         = n_q;
    iter_d      = iter_q;
    alpha_d     = alpha_q;
    bc_d        = bc_q;
    bnd_d       = bnd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    we          = 1'b0;
    wbank       = bank_q;
    waddr       = cmd_addr;
    wdata       = cmd_data[TW-1:0];
`ifdef STENCIL_CONVERGE_EN
    thr_d       = thr_q;
    drun_d      = drun_q;
    mdel_d      = mdel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op_run: begin
              n_d    = cmd_data;
              iter_d = '0;
              k_d    = '0;
            end
            op_wr: we = 1'b1;
            op_rd: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = mem_q[bank_q][cmd_addr];
            end
            op_cfg: begin
              if (cmd_addr == AW'(0)) begin
                alpha_d = cmd_data[1:0];
                bc_d    = cmd_data[2];
              end
              if (cmd_addr == AW'(1))
                bnd_d = cmd_data[TW-1:0];
`ifdef STENCIL_CONVERGE_EN
              if (cmd_addr == AW'(2))
                thr_d = cmd_data[TW-1:0];
`endif
            end
            default: ;
          endcase
        end
      end
      S_SWEEP: begin
        we    = 1'b1;
        wbank = ~bank_q;
        waddr = k_q;
        wdata = new_val;
        k_d   = abort ? '0 : k_q + AW'(1);
`ifdef STENCIL_CONVERGE_EN
        if (k_q == '0 || dlt > drun_q) drun_d = dlt;
`endif
      end
      S_SWAP: begin
        k_d = '0;
        if (!abort) begin
          bank_d = ~bank_q;
          iter_d = iter_next;
`ifdef STENCIL_CONVERGE_EN
          mdel_d = drun_q;
`endif
        end
      end
      S_DONE:  k_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= 1'b0;
      k_q         <= '0;
      n_q         <= '0;
      iter_q      <= '0;
      alpha_q     <= 2'b01;
      bc_q        <= 1'b0;
      bnd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef STENCIL_CONVERGE_EN
      thr_q       <= '0;
      drun_q      <= '0;
      mdel_q      <= '0;
`endif
    end else begin
      bank_q      <= bank_d;
      k_q         <= k_d;
      n_q         <= n_d;
      iter_q      <= iter_d;
      alpha_q     <= alpha_d;
      bc_q        <= bc_d;
      bnd_q       <= bnd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef STENCIL_CONVERGE_EN
      thr_q       <= thr_d;
      drun_q      <= drun_d;
      mdel_q      <= mdel_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < CELLS; i++)
          mem_q[b][i] <= '0;
    end else if (we) begin
      mem_q[wbank][waddr] <= wdata;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign iter_count = iter_q;

endmodule

// File: doc/stencil_jacobi_solver.md
# stencil_jacobi_solver

Parametrised 2-D heat-equation (5-point stencil) solver that generalises the team's fixed 8x8, 4-bit grid engine to configurable grid dimensions and temperature width. It uses Jacobi (double-buffered) updates instead of in-place updates, and selectable Dirichlet or insulated boundaries. A command handshake loads and reads cells and launches N-iteration runs with abort support. The block sits behind the chip I/O command decoder and owns all grid storage.

## Interface
- GRID_W, 8: grid columns, power of two, 4..16.
- GRID_H, 8: grid rows, power of two, 4..16.
- TW, 6: temperature width in bits.
- ITER_W, 12: iteration counter and cmd_data width; must be at least TW.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 RUN, 01 WRITE, 10 READ, 11 CONFIG.
- cmd_addr  in  AW=log2(GRID_W*GRID_H)  cell index {y,x}, or config register select.
- cmd_data  in  ITER_W  write data (low TW bits), config value, or RUN iteration count N.
- abort  in  1  stop the current run.
- rsp_valid  out  1  one-cycle pulse carrying READ data.
- rsp_data  out  TW  READ data.
- busy  out  1  high in SWEEP and SWAP.
- done  out  1  one-cycle pulse when a run ends.
- iter_count  out  ITER_W  iterations completed in the last or current run.
- max_delta  out  TW  largest |T_new-T_old| of the last completed sweep.

## Operation
- Storage: two banks of GRID_W*GRID_H cells, TW bits each.
- bank_sel selects the current bank; reads and writes target the current bank.
- Config registers:
  - addr 0: alpha = data[1:0], bc_mode = data[2].
  - addr 1: boundary = data[TW-1:0].
  - addr 2: threshold = data[TW-1:0].
  - Other addresses are ignored.
- Handshake: a command is accepted when cmd_valid && cmd_ready. WRITE and CONFIG take effect in the accept cycle. READ returns rsp_valid/rsp_data on the next cycle.
- FSM states: IDLE, SWEEP, SWAP, DONE.
  - IDLE, RUN accepted with N=0 -> DONE.
  - IDLE, RUN accepted with N>0 -> SWEEP; iter_count cleared.
  - SWEEP: visits cell k = 0..CELLS-1 in raster order, one cell per cycle. Reads the current bank and writes the result to the other bank at index k. After the last cell -> SWAP.
  - SWAP: toggles bank_sel, increments iter_count, latches max_delta. Goes to DONE if iter_count==N or the convergence stop hits; otherwise back to SWEEP.
  - DONE: asserts done for one cycle, then IDLE.
- Abort: abort in SWEEP or SWAP -> DONE next cycle. The partial sweep is discarded, bank_sel is not toggled, and iter_count holds the completed iterations only.
- Stencil arithmetic:
  - Neighbour addresses clamp at the edges, so an edge cell uses itself as the missing neighbour.
  - sum = L+R+U+D, TW+2 bits. avg = sum>>2.
  - Intermediates are TW+3 bits; results truncate (floor) to TW bits.
  - alpha 00: (7C+avg)>>3.
  - alpha 01: (3C+avg)>>2.
  - alpha 10: (C+avg)>>1.
  - alpha 11: (C+3avg)>>2.
- Boundaries:
  - bc_mode 0 (Dirichlet): edge cells get `boundary`.
  - bc_mode 1 (insulated): edge cells use the clamped stencil result.
- Reset values:
  - Both banks 0, bank_sel 0.
  - alpha 01, bc_mode 0, boundary 0, threshold 0.
  - All outputs 0 except cmd_ready, which is 1 (IDLE).
- Reset asserted mid-run returns the block to IDLE next cycle with all state reset; done is not pulsed.

## Timing
- cmd_ready is combinational from state only, never from cmd_valid.
- With CELLS = GRID_W*GRID_H, a RUN accepted at cycle t:
  - enters SWEEP at t+1;
  - spends CELLS+1 cycles per iteration;
  - pulses done at t+1+N*(CELLS+1).
- N=0: done pulses at t+1.
- busy is high for the cycles from t+1 up to, but not including, the done cycle.
- READ latency is 1 cycle. A WRITE followed back-to-back by a READ to the same address returns the new value.
- abort in IDLE or DONE is ignored. abort has priority over the normal SWAP transition.

## Configuration
- STENCIL_CONVERGE_EN defined:
  - SWEEP tracks the running maximum of |T_new-T_old| over all cells.
  - SWAP ends the run early if that maximum is <= threshold.
  - max_delta reports the maximum.
- STENCIL_CONVERGE_EN undefined:
  - No delta logic; runs always execute exactly N iterations unless aborted.
  - max_delta is tied to 0.
  - CONFIG addr 2 is ignored.

## Test plan
- Reset, then READ all 64 cells -> rsp_data 0 each, rsp_valid exactly 1 cycle after each accept, cmd_ready=1.
- 8x8, TW=6, alpha=10, bc_mode=0, boundary 0; write cell (x3,y3)=63; RUN N=1:
  - done at t+66.
  - (3,3)=31, (3,4)=7, (3,5)=0 (this proves Jacobi, not in-place).
  - iter_count=1.
- boundary=20; RUN N=1 -> all 28 edge cells read 20, interior unchanged where its neighbours were 0.
- bc_mode=1, all cells 10; RUN N=5 -> every cell still 10, done at t+1+5*65.
- RUN N=3, assert abort on the 40th SWEEP cycle of iteration 2 -> done next cycle, iter_count=1, grid equals the 1-iteration result.
- With STENCIL_CONVERGE_EN, threshold 0, all cells 0, boundary 0; RUN N=100 -> done after 1 iteration, iter_count=1, max_delta=0. Without the macro -> iter_count=100.
